hs_arb_fifo: RTL

//  Clocked, parametrised successor to the 2-input handshake mux/merge stages.

---
 rtl/hs_arb_fifo_if.sv | 29 ++
 rtl/hs_arb_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_arb_fifo_if.sv
// Handshake bundle for hs_arb_fifo: N_CH four-phase producer channels in,
// one buffered four-phase channel out, plus FIFO occupancy.
interface hs_arb_fifo_if #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int SW = $clog2(N_CH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [N_CH-1:0]   in_req;
    logic [N_CH-1:0]   in_ack;
    logic [N_CH*W-1:0] in_data;
    logic              out_req;
    logic              out_ack;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_src;
    logic [LW-1:0]     level;

    modport master (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, out_src, level
    );

    modport slave (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, out_src, level
    );
endinterface

// File: rtl/hs_arb_fifo.sv
// Round-robin merge of N_CH four-phase producer channels into one buffered
// four-phase output; each item carries the index of its source channel.
//
// Output FSM states:
//   state  | meaning
//   O_IDLE | out_req=0, waiting for a non-empty FIFO
//   O_REQ  | out_req=1, head presented, waiting for ak=1
//   O_WAIT | head popped, out_req=0, waiting for ak=0
module hs_arb_fifo #(
    parameter int N_CH        = 4,
    parameter int W           = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    hs_arb_fifo_if.slave  bus
);
    localparam int SW = $clog2(N_CH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = SW + W;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT} ostate_e;

    logic [N_CH-1:0] rq;
    logic            ak;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rq = bus.in_req;
            assign ak = bus.out_ack;
        end else begin : g_sync
            logic [N_CH-1:0]        rq_sync_q [SYNC_STAGES];
            logic [SYNC_STAGES-1:0] ak_sync_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        rq_sync_q[s] <= '0;
                    end
                    ak_sync_q <= '0;
                end else begin
                    rq_sync_q[0] <= bus.in_req;
                    ak_sync_q[0] <= bus.out_ack;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        rq_sync_q[s] <= rq_sync_q[s-1];
                        ak_sync_q[s] <= ak_sync_q[s-1];
                    end
                end
            end

            assign rq = rq_sync_q[SYNC_STAGES-1];
            assign ak = ak_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [W-1:0] ch_data [N_CH];

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_data
            assign ch_data[c] = bus.in_data[c*W +: W];
        end
    endgenerate

    logic [N_CH-1:0] ack_q, ack_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [N_CH-1:0] cand;
    logic [SW-1:0]   idx;
    logic [SW-1:0]   gnt_idx;
    logic            push;
    logic            pop;
    logic            load;

    ostate_e ost_q, ost_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_src_q;

    // A channel is a candidate only in IDLE, so each four-phase cycle yields one item.
    assign cand = rq & ~ack_q;

    always_comb begin
        push    = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = SW'((int'(ptr_q) + i) % N_CH);
            if (!push && cand[idx]) begin
                push    = 1'b1;
                gnt_idx = idx;
            end
        end
        if (level_q == FULL) begin
            push = 1'b0;
        end
    end

    always_comb begin
        ack_d = ack_q;
        for (int c = 0; c < N_CH; c++) begin
            if (ack_q[c]) begin
                ack_d[c] = rq[c];
            end else begin
                ack_d[c] = push && (gnt_idx == SW'(c));
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) begin
            ptr_d = (gnt_idx == SW'(N_CH - 1)) ? '0 : gnt_idx + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ost_q <= O_IDLE;
        end else begin
            ost_q <= ost_d;
        end
    end

    always_comb begin
        ost_d = ost_q;
        case (ost_q)
            O_IDLE:  if (level_q != '0) ost_d = O_REQ;
            O_REQ:   if (ak)            ost_d = O_WAIT;
            O_WAIT:  if (!ak)           ost_d = O_IDLE;
            default:                    ost_d = O_IDLE;
        endcase
    end

    always_comb begin
        load        = 1'b0;
        pop         = 1'b0;
        bus.out_req = 1'b0;
        case (ost_q)
            O_IDLE:  load = (level_q != '0);
            O_REQ: begin
                bus.out_req = 1'b1;
                pop         = ak;
            end
            default: ;
        endcase
    end

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q      <= '0;
            ptr_q      <= '0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            ptr_q    <= ptr_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (load) begin
                out_data_q <= mem_q[rd_ptr_q][W-1:0];
                out_src_q  <= mem_q[rd_ptr_q][EW-1:W];
            end
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {gnt_idx, ch_data[gnt_idx]};
        end
    end

    assign bus.in_ack   = ack_q;
    assign bus.out_data = out_data_q;
    assign bus.out_src  = out_src_q;
    assign bus.level    = level_q;

endmodule
